pixel_buffer: RTL
=================

# pixel_buffer

Parametrised on-chip pixel store for the rotate datapath, replacing the fixed 64×8, 4-in/3-out input memory. Write lanes, read ports, depth and pixel width are configurable, and each write lane has its own enable. An optional ping-pong mode lets the bus side fill one bank while the rotate engine reads the other, with a request/acknowledge bank swap.

## Interface
- PIX_W, 8, bits per pixel
- DEPTH, 64, pixels per bank; AW = $clog2(DEPTH)
- WR_LANES, 4, pixels written per cycle (packed bus word)
- RD_PORTS, 3, independent read ports (B/G/R in the default use)
- DOUBLE_BUF, 0, 0 = single bank; 1 = two banks with swap handshake

- I_HCLK  in  1  sole clock, rising edge
- I_HRESET  in  1  reset; synchronous, active-high
- I_WR_DATA  in  WR_LANES*PIX_W  lane k occupies bits [k*PIX_W +: PIX_W]
- I_WR_ADDR  in  WR_LANES*AW  lane k address
- I_WR_EN  in  WR_LANES  per-lane write enable
- I_RD_ADDR  in  RD_PORTS*AW  port j address
- I_RD_EN  in  RD_PORTS  per-port read enable
- I_SWAP_REQ  in  1  level request to exchange banks (ignored when DOUBLE_BUF=0)
- O_SWAP_ACK  out  1  one-cycle pulse when the swap takes effect
- O_WR_BANK  out  1  bank currently written; reads use the other bank
- O_RD_DATA  out  RD_PORTS*PIX_W  port j read data
- O_RD_VALID  out  RD_PORTS  port j data valid

## Operation
- **Storage.** DEPTH×(1+DOUBLE_BUF) entries. Physical index = {bank, addr}. In single mode the bank bit is absent and reads and writes share one array.
- **Writes.** Each enabled lane writes its pixel to the write bank.
  - Addr ≥ DEPTH: the lane is dropped.
  - Two enabled lanes with the same address: the highest lane index wins.
- **Reads.** Each enabled port reads the read bank.
  - In single mode the read bank equals the write bank.
  - Addr ≥ DEPTH returns 0 with valid still asserted.
- **Swap FSM** (DOUBLE_BUF=1 only):
  - IDLE: if I_SWAP_REQ, go to WAIT.
  - WAIT: on the first cycle with I_WR_EN==0 and I_RD_EN==0, toggle O_WR_BANK, pulse O_SWAP_ACK, go to HOLD. Accesses during WAIT complete normally on the old banks.
  - HOLD: when I_SWAP_REQ==0, go to IDLE. A request held high never causes a second swap.
- **DOUBLE_BUF=0.** O_SWAP_ACK and O_WR_BANK are tied to 0; the FSM is not instantiated.

## Timing
- Write latency: the entry is updated at the edge that samples I_WR_EN.
- Read latency: 1 cycle.
  - O_RD_DATA[j] and O_RD_VALID[j] update at the edge that samples I_RD_EN[j].
  - When I_RD_EN[j]=0, valid drops to 0 and data holds its last value.
- Same-cycle read and write to the same physical entry: see Configuration.
- Swap: O_WR_BANK changes at the same edge where O_SWAP_ACK rises. Accesses in the following cycle use the new banks.
- Reset (any cycle, including mid-WAIT):
  - All entries, O_RD_DATA and O_RD_VALID go to 0.
  - O_WR_BANK goes to 0, O_SWAP_ACK to 0, and the FSM to IDLE.
  - All of this takes effect in one cycle. Inputs are ignored during reset.

## Configuration
- **PIXEL_BUF_FWD_EN defined:** write-to-read forwarding.
  - A read whose physical index matches an enabled write lane in the same cycle returns that lane's I_WR_DATA.
  - If several lanes match, the highest lane index is returned, consistent with write collision.
- **PIXEL_BUF_FWD_EN undefined:** read-before-write; the read returns the prior stored value.
- In DOUBLE_BUF=1 the bank indices never match, so forwarding never triggers.

## Structure
- Package pixel_buf_pkg holds:
  - the default parameter values;
  - a function for the AW computation;
  - FSM state encodings IDLE=2'd0, WAIT=2'd1, HOLD=2'd2.
- One sub-module: pixel_buf_swap_fsm, containing the swap FSM, the O_WR_BANK register and ACK generation.
- Storage, lane decode and read muxing stay in pixel_buffer.

## Test plan
- **Default params, lane write/readback.** Write 0x44332211 to addrs 0,1,2,3 with all lanes enabled. Read ports B/G/R at addrs 1,2,3 the next cycle → 0x22, 0x33, 0x44 one cycle later, valid=111.
- **Collision and per-lane enable.** Lanes 0 and 2 both write addr 5 with data 0xAA and 0xCC; lanes 1 and 3 disabled. A later read of addr 5 → 0xCC. Disabled lanes' addresses keep their old contents.
- **Same-cycle forwarding.** Entry 7 holds 0x11. Write 0x5A to addr 7 and read addr 7 in the same cycle.
  - With PIXEL_BUF_FWD_EN → 0x5A.
  - Without it → 0x11.
- **Out of range (DEPTH=48).** Write addr 50 → dropped. Read addr 50 → 0x00 with valid=1.
- **Double-buffer swap (DOUBLE_BUF=1).** Fill bank 0, then raise I_SWAP_REQ while writes continue for 3 cycles.
  - ACK must pulse only on the first idle cycle.
  - O_WR_BANK goes 0→1.
  - Reads afterwards return the bank-0 data.
  - Holding REQ high produces no second ACK.
- **Reset mid-WAIT.** Assert I_HRESET during WAIT → ACK=0, O_WR_BANK=0, all outputs 0, and a read after reset returns 0.

Source files
------------

// File: rtl/pixel_buf_pkg.sv
// pixel_buf_pkg: default parameters, address-width helper and swap FSM encodings for pixel_buffer.
package pixel_buf_pkg;
   localparam int PIX_W_DEF      = 8;
   localparam int DEPTH_DEF      = 64;
   localparam int WR_LANES_DEF   = 4;
   localparam int RD_PORTS_DEF   = 3;
   localparam int DOUBLE_BUF_DEF = 0;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   function automatic int aw_f(input int depth);
      return depth > 1 ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/pixel_buf_swap_fsm.sv
// pixel_buf_swap_fsm: request/acknowledge bank swap; toggles the write bank on the first idle cycle after a request.
module pixel_buf_swap_fsm
   import pixel_buf_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic req_i,
   input  logic idle_i,
   output logic ack_o,
   output logic bank_o
);
   logic [1:0] state_q, state_d;
   logic bank_q, bank_d, ack_q, ack_d;

   // HOLD waits for the request to drop so a held request swaps only once.
   always_comb begin
      state_d = state_q;
      bank_d  = bank_q;
      ack_d   = 1'b0;
      if (state_q == IDLE && req_i) state_d = WAIT;
      if (state_q == WAIT && idle_i) begin
         state_d = HOLD;
         bank_d  = ~bank_q;
         ack_d   = 1'b1;
      end
      if (state_q == HOLD && !req_i) state_d = IDLE;
   end

   always_ff @(posedge clk_i)
      if (rst_i) begin
         state_q <= IDLE;
         bank_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bank_q  <= bank_d;
         ack_q   <= ack_d;
      end

   assign ack_o  = ack_q;
   assign bank_o = bank_q;
endmodule

// File: rtl/pixel_buffer.sv
// pixel_buffer: multi-lane pixel store with optional ping-pong banks; PIXEL_BUF_FWD_EN enables same-cycle write-to-read forwarding.
module pixel_buffer
   import pixel_buf_pkg::*;
#(
   parameter int PIX_W      = PIX_W_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int WR_LANES   = WR_LANES_DEF,
   parameter int RD_PORTS   = RD_PORTS_DEF,
   parameter int DOUBLE_BUF = DOUBLE_BUF_DEF,
   localparam int AW        = aw_f(DEPTH)
) (
   input  logic                         I_HCLK,
   input  logic                         I_HRESET,
   input  logic [WR_LANES*PIX_W-1:0]    I_WR_DATA,
   input  logic [WR_LANES*AW-1:0]       I_WR_ADDR,
   input  logic [WR_LANES-1:0]          I_WR_EN,
   input  logic [RD_PORTS*AW-1:0]       I_RD_ADDR,
   input  logic [RD_PORTS-1:0]          I_RD_EN,
   input  logic                         I_SWAP_REQ,
   output logic                         O_SWAP_ACK,
   output logic                         O_WR_BANK,
   output logic [RD_PORTS*PIX_W-1:0]    O_RD_DATA,
   output logic [RD_PORTS-1:0]          O_RD_VALID
);
   localparam int NENT = DOUBLE_BUF != 0 ? 2 * DEPTH : DEPTH;
   localparam int IW   = $clog2(NENT);

   logic [PIX_W-1:0] mem_q [NENT];
   logic [AW-1:0]    wa [WR_LANES];
   logic [PIX_W-1:0] wd [WR_LANES];
   logic             wr_bank, rd_bank;

   function automatic logic [IW-1:0] phys(input logic bank, input logic [AW-1:0] addr);
      return (bank ? IW'(DEPTH) : '0) + IW'(addr);
   endfunction

   assign rd_bank   = DOUBLE_BUF != 0 ? ~wr_bank : wr_bank;
   assign O_WR_BANK = wr_bank;

   always_comb
      for (int k = 0; k < WR_LANES; k++) begin
         wa[k] = I_WR_ADDR[k*AW +: AW];
         wd[k] = I_WR_DATA[k*PIX_W +: PIX_W];
      end

   // Lanes are visited low to high so the highest enabled lane wins a collision.
   always_ff @(posedge I_HCLK)
      if (I_HRESET)
         for (int i = 0; i < NENT; i++) mem_q[IW'(i)] <= '0;
      else
         for (int k = 0; k < WR_LANES; k++)
            if (I_WR_EN[k] && int'(wa[k]) < DEPTH) mem_q[phys(wr_bank, wa[k])] <= wd[k];

   for (genvar j = 0; j < RD_PORTS; j++) begin : g_rd
      logic [AW-1:0]    ra;
      logic [PIX_W-1:0] data_d, data_q;
      logic             valid_q;
      assign ra = I_RD_ADDR[j*AW +: AW];
      always_comb begin
         data_d = int'(ra) < DEPTH ? mem_q[phys(rd_bank, ra)] : '0;
`ifdef PIXEL_BUF_FWD_EN
         for (int k = 0; k < WR_LANES; k++)
            if (DOUBLE_BUF == 0 && I_WR_EN[k] && wa[k] == ra && int'(ra) < DEPTH) data_d = wd[k];
`endif
      end
      always_ff @(posedge I_HCLK)
         if (I_HRESET) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= I_RD_EN[j];
            if (I_RD_EN[j]) data_q <= data_d;
         end
      assign O_RD_DATA[j*PIX_W +: PIX_W] = data_q;
      assign O_RD_VALID[j]               = valid_q;
   end

   if (DOUBLE_BUF != 0) begin : g_swap
      logic idle;
      assign idle = ~|I_WR_EN & ~|I_RD_EN;
      pixel_buf_swap_fsm u_swap (
         .clk_i  (I_HCLK),
         .rst_i  (I_HRESET),
         .req_i  (I_SWAP_REQ),
         .idle_i (idle),
         .ack_o  (O_SWAP_ACK),
         .bank_o (wr_bank)
      );
   end else begin : g_single
      logic unused_req;
      assign unused_req = I_SWAP_REQ;
      assign O_SWAP_ACK = 1'b0;
      assign wr_bank    = 1'b0;
   end
endmodule
